pipe_hazard_ctrl: RTL and testbench

- Hazard and run controller for the 5-stage Y86-64 pipeline.
- Each cycle it produces stall and bubble controls for the F/D/E/M/W pipeline registers.
- It also sequences the run state: IDLE, then RUN, then DONE on halt or exception.
- It latches the architectural CPU status and keeps saturating performance counters for the testbench and debug.

---
 rtl/pipe_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and run controller for a 5-stage Y86-64 pipeline: per-cycle stall/bubble controls,
// IDLE/RUN/DONE sequencing, latched CPU status and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [2:0]       cpu_stat,
  output logic             running,
  output logic             done,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] INop    = 4'd1;
  localparam logic [3:0] IMrmovq = 4'd5;
  localparam logic [3:0] IJxx    = 4'd7;
  localparam logic [3:0] IRet    = 4'd9;
  localparam logic [3:0] IPopq   = 4'd11;
  localparam logic [3:0] RNone   = 4'd15;
  localparam logic [2:0] SAok    = 3'd1;
  localparam logic [2:0] SAdr    = 3'd2;
  localparam logic [2:0] SIns    = 3'd3;
  localparam logic [2:0] SHlt    = 3'd4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic             armed_q;
  logic [2:0]       stat_q;
  logic [CNT_W-1:0] cycle_q, retired_q, stall_q, mispred_q;

  logic lu, rt, mp, ex_m, ex_w, retire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    lu     = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != RNone) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt     = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
    mp     = (E_icode == IJxx) && !e_Cnd;
    ex_m   = (m_stat == SAdr) || (m_stat == SIns) || (m_stat == SHlt);
    ex_w   = (W_stat == SAdr) || (W_stat == SIns) || (W_stat == SHlt);
    retire = (W_stat == SAok) && (W_icode != INop);
  end

  // Outside RUN every stage is frozen so architectural state cannot change.
  always_comb begin
    if (state_q == StRun) begin
      F_stall  = lu | rt;
      D_stall  = lu;
      D_bubble = mp | (rt & ~lu);
      E_bubble = mp | lu;
      M_bubble = ex_m | ex_w;
      W_stall  = ex_w;
    end else begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      D_bubble = 1'b0;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_stall  = 1'b1;
    end
  end

  // armed_q masks a start pulse on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      armed_q   <= 1'b0;
      stat_q    <= SAok;
      cycle_q   <= '0;
      retired_q <= '0;
      stall_q   <= '0;
      mispred_q <= '0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start && armed_q) state_q <= StRun;
        end
        StRun: begin
          cycle_q <= sat_inc(cycle_q);
          if (retire)   retired_q <= sat_inc(retired_q);
          if (lu || rt) stall_q   <= sat_inc(stall_q);
          if (mp)       mispred_q <= sat_inc(mispred_q);
          if (W_stat != SAok) begin
            state_q <= StDone;
            stat_q  <= W_stat;
          end
        end
        StDone: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign running     = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign cpu_stat    = stat_q;
  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences and randomized
// stimulus against a behavioural model; a second 4-bit-counter instance covers saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n, start, e_Cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
  logic [2:0] m_stat, W_stat;

  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, running, done;
  logic [2:0]  cpu_stat;
  logic [31:0] cycle_cnt, retired_cnt, stall_cnt, mispred_cnt;

  logic s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_running, s_done;
  logic [2:0] s_cpu_stat;
  logic [3:0] s_cycle_cnt, s_retired_cnt, s_stall_cnt, s_mispred_cnt;

  pipe_hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall),
    .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
    .W_stall(W_stall), .cpu_stat(cpu_stat), .running(running), .done(done),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt),
    .mispred_cnt(mispred_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .D_icode(D_icode), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode),
    .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat), .F_stall(s_F_stall),
    .D_stall(s_D_stall), .D_bubble(s_D_bubble), .E_bubble(s_E_bubble), .M_bubble(s_M_bubble),
    .W_stall(s_W_stall), .cpu_stat(s_cpu_stat), .running(s_running), .done(s_done),
    .cycle_cnt(s_cycle_cnt), .retired_cnt(s_retired_cnt), .stall_cnt(s_stall_cnt),
    .mispred_cnt(s_mispred_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: 0 idle, 1 run, 2 done; counters are unbounded and clipped on compare.
  int     mstate;
  bit     armed;
  longint m_cyc, m_ret, m_stall, m_mis;
  int     m_cpu;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit is_exc(input logic [2:0] s);
    return s inside {3'd2, 3'd3, 3'd4};
  endfunction

  function automatic bit hz_lu();
    return (E_icode inside {4'd5, 4'd11}) && E_dstM != 4'd15 &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction

  function automatic bit hz_rt();
    return D_icode == 4'd9 || E_icode == 4'd9 || M_icode == 4'd9;
  endfunction

  function automatic bit hz_mp();
    return E_icode == 4'd7 && !e_Cnd;
  endfunction

  // Order: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall.
  function automatic logic [5:0] ref_ctrl();
    bit lu, rt, mp;
    if (mstate != 1) return 6'b110111;
    lu = hz_lu(); rt = hz_rt(); mp = hz_mp();
    return {lu | rt, lu, mp | (rt & !lu), mp | lu, is_exc(m_stat) | is_exc(W_stat),
            is_exc(W_stat)};
  endfunction

  task automatic model_edge();
    if (mstate == 0) begin
      if (start && armed) mstate = 1;
    end else if (mstate == 1) begin
      m_cyc++;
      if (W_stat == 3'd1 && W_icode != 4'd1) m_ret++;
      if (hz_lu() || hz_rt()) m_stall++;
      if (hz_mp()) m_mis++;
      if (W_stat != 3'd1) begin
        mstate = 2;
        m_cpu  = int'(W_stat);
      end
    end
    armed = 1'b1;
  endtask

  task automatic set_in(input logic [3:0] di, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [3:0] ei, input logic [3:0] dm, input logic cnd,
                        input logic [3:0] mi, input logic [2:0] ms, input logic [3:0] wi,
                        input logic [2:0] ws);
    D_icode = di; d_srcA = sa; d_srcB = sb; E_icode = ei; E_dstM = dm; e_Cnd = cnd;
    M_icode = mi; m_stat = ms; W_icode = wi; W_stat = ws;
  endtask

  task automatic set_nop();
    set_in(4'd1, 4'd15, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 3'd1, 4'd1, 3'd1);
  endtask

  // Inputs are driven just after a rising edge; checks happen on the falling edge.
  task automatic step(input string nm, input logic [5:0] exp = 6'b0, input bit use_exp = 1'b0);
    logic [5:0] ctrl;
    @(negedge clk);
    ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
    chk({nm, "_ctrl"}, 64'(ctrl), 64'(ref_ctrl()));
    if (use_exp) chk({nm, "_tbl"}, 64'(ctrl), 64'(exp));
    chk({nm, "_running"}, 64'(running), 64'(mstate == 1));
    chk({nm, "_done"}, 64'(done), 64'(mstate == 2));
    chk({nm, "_cpu_stat"}, 64'(cpu_stat), 64'(m_cpu));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_counters(input string nm);
    chk({nm, "_cycle"}, 64'(cycle_cnt), 64'(sat(m_cyc, 32)));
    chk({nm, "_retired"}, 64'(retired_cnt), 64'(sat(m_ret, 32)));
    chk({nm, "_stall"}, 64'(stall_cnt), 64'(sat(m_stall, 32)));
    chk({nm, "_mispred"}, 64'(mispred_cnt), 64'(sat(m_mis, 32)));
    chk({nm, "_s_cycle"}, 64'(s_cycle_cnt), 64'(sat(m_cyc, 4)));
    chk({nm, "_s_stall"}, 64'(s_stall_cnt), 64'(sat(m_stall, 4)));
  endtask

  // Reset is released just after a rising edge; start_at_release is held over the next edge.
  task automatic do_reset(input logic start_at_release);
    rst_n = 1'b0;
    start = 1'b0;
    set_nop();
    mstate = 0; armed = 1'b0; m_cpu = 1;
    m_cyc = 0; m_ret = 0; m_stall = 0; m_mis = 0;
    repeat (2) @(posedge clk);
    #1;
    start = start_at_release;
    rst_n = 1'b1;
    step("release");
    start = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step("start");
    start = 1'b0;
  endtask

  typedef struct {
    logic [3:0] di, sa, sb, ei, dm;
    logic       cnd;
    logic [3:0] mi;
    logic [2:0] ms;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    longint     c0, r0, s0, i0;
    logic [3:0] smallpool[6];
    smallpool = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd15};

    tbl[0]  = '{4'd1, 4'd15, 4'd15, 4'd1,  4'd15, 1'b1, 4'd1, 3'd1, 6'b000000};
    tbl[1]  = '{4'd6, 4'd3,  4'd15, 4'd5,  4'd3,  1'b1, 4'd1, 3'd1, 6'b110100};
    tbl[2]  = '{4'd6, 4'd3,  4'd15, 4'd5,  4'd15, 1'b1, 4'd1, 3'd1, 6'b000000};
    tbl[3]  = '{4'd6, 4'd2,  4'd4,  4'd11, 4'd4,  1'b1, 4'd1, 3'd1, 6'b110100};
    tbl[4]  = '{4'd6, 4'd2,  4'd3,  4'd5,  4'd4,  1'b1, 4'd1, 3'd1, 6'b000000};
    tbl[5]  = '{4'd1, 4'd15, 4'd15, 4'd7,  4'd15, 1'b0, 4'd1, 3'd1, 6'b001100};
    tbl[6]  = '{4'd1, 4'd15, 4'd15, 4'd7,  4'd15, 1'b1, 4'd1, 3'd1, 6'b000000};
    tbl[7]  = '{4'd9, 4'd4,  4'd15, 4'd1,  4'd15, 1'b1, 4'd1, 3'd1, 6'b101000};
    tbl[8]  = '{4'd1, 4'd15, 4'd15, 4'd1,  4'd15, 1'b1, 4'd9, 3'd1, 6'b101000};
    tbl[9]  = '{4'd9, 4'd3,  4'd15, 4'd5,  4'd3,  1'b1, 4'd1, 3'd1, 6'b110100};
    tbl[10] = '{4'd1, 4'd15, 4'd15, 4'd1,  4'd15, 1'b1, 4'd1, 3'd2, 6'b000010};
    tbl[11] = '{4'd1, 4'd15, 4'd15, 4'd7,  4'd15, 1'b0, 4'd1, 3'd3, 6'b001110};
    tbl[12] = '{4'd1, 4'd15, 4'd15, 4'd1,  4'd15, 1'b1, 4'd1, 3'd0, 6'b000000};

    // Reset, then ten idle clocks with start never pulsed.
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step("idle");
    chk("idle_F_stall", 64'(F_stall), 64'd1);
    chk("idle_E_bubble", 64'(E_bubble), 64'd1);
    chk("idle_running", 64'(running), 64'd0);
    chk("idle_cycle_cnt", 64'(cycle_cnt), 64'd0);

    // Start held across reset release must be ignored.
    do_reset(1'b1);
    step("after_release");
    chk("release_start_ignored", 64'(running), 64'd0);

    pulse_start();
    chk("run_entered", 64'(running), 64'd1);

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].di, tbl[i].sa, tbl[i].sb, tbl[i].ei, tbl[i].dm, tbl[i].cnd, tbl[i].mi,
             tbl[i].ms, 4'd2, 3'd1);
      step($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
    end
    check_counters("after_table");

    // Ret held in D for three cycles, with a load/use added in the middle cycle.
    s0 = longint'(stall_cnt);
    set_in(4'd9, 4'd4, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 3'd1, 4'd1, 3'd1);
    step("ret1", 6'b101000, 1'b1);
    set_in(4'd9, 4'd4, 4'd15, 4'd5, 4'd4, 1'b1, 4'd1, 3'd1, 4'd1, 3'd1);
    step("ret2_lu", 6'b110100, 1'b1);
    set_in(4'd9, 4'd4, 4'd15, 4'd1, 4'd15, 1'b1, 4'd1, 3'd1, 4'd1, 3'd1);
    step("ret3", 6'b101000, 1'b1);
    chk("ret_stall_delta", 64'(longint'(stall_cnt) - s0), 64'd3);

    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom_range(0, 11)), smallpool[$urandom_range(0, 5)],
             smallpool[$urandom_range(0, 5)], 4'($urandom_range(0, 11)),
             smallpool[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 11)),
             ($urandom_range(0, 7) < 6) ? 3'd1 : 3'($urandom_range(2, 4)),
             4'($urandom_range(0, 11)), 3'd1);
      step("rnd");
    end
    check_counters("after_random");
    chk("sat_cycle_cnt", 64'(s_cycle_cnt), 64'd15);

    // Halt reaches W: flush that cycle, then DONE with counters frozen.
    set_nop();
    W_stat = 3'd4;
    step("halt", 6'b000011, 1'b1);
    chk("halt_done", 64'(done), 64'd1);
    chk("halt_cpu_stat", 64'(cpu_stat), 64'd4);
    check_counters("at_halt");
    c0 = longint'(cycle_cnt); r0 = longint'(retired_cnt);
    s0 = longint'(stall_cnt); i0 = longint'(mispred_cnt);
    set_in(4'd9, 4'd3, 4'd15, 4'd7, 4'd3, 1'b0, 4'd9, 3'd2, 4'd2, 3'd1);
    step("done1");
    pulse_start();
    step("done2");
    chk("done_sticky", 64'(done), 64'd1);
    chk("frozen_cycle", 64'(cycle_cnt), 64'(c0));
    chk("frozen_retired", 64'(retired_cnt), 64'(r0));
    chk("frozen_stall", 64'(stall_cnt), 64'(s0));
    chk("frozen_mispred", 64'(mispred_cnt), 64'(i0));

    // Asynchronous reset in the middle of RUN takes effect before the next edge.
    do_reset(1'b0);
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      set_in(4'd1, 4'd3, 4'd15, 4'd5, 4'd3, 1'b1, 4'd1, 3'd1, 4'd2, 3'd1);
      step("pre_async");
    end
    check_counters("pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_cycle_cnt", 64'(cycle_cnt), 64'd0);
    chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("async_retired_cnt", 64'(retired_cnt), 64'd0);
    chk("async_F_stall", 64'(F_stall), 64'd1);
    chk("async_D_bubble", 64'(D_bubble), 64'd0);
    chk("async_running", 64'(running), 64'd0);
    chk("async_cpu_stat", 64'(cpu_stat), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
